// File: rtl/nzr_receiver_if.sv
// ---------------------------------------------------------------------------
// nzr_receiver_if
//   Bundles the one-wire pixel line and the decoded-colour outputs of
//   nzr_receiver.
//
//   dataIn      raw NZR line into the receiver (asynchronous to clk)
//   dataOut     forwarded stream for the next pixel in the chain
//   grb[23:0]   last latched colour, bit 23 = first bit received (G7)
//   colorValid  one-cycle pulse when grb updates
//   frameErr    one-cycle pulse on a frame error
//   rxBusy      high while the receiver is not idle
//
//   modport slave  : the receiver (reads dataIn, drives everything else)
//   modport master : the line driver / observer (drives dataIn)
// ---------------------------------------------------------------------------
interface nzr_receiver_if;
    logic        dataIn;
    logic        dataOut;
    logic [23:0] grb;
    logic        colorValid;
    logic        frameErr;
    logic        rxBusy;

    modport master (
        output dataIn,
        input  dataOut,
        input  grb,
        input  colorValid,
        input  frameErr,
        input  rxBusy
    );

    modport slave (
        input  dataIn,
        output dataOut,
        output grb,
        output colorValid,
        output frameErr,
        output rxBusy
    );
endinterface

// File: rtl/nzr_receiver.sv
// ---------------------------------------------------------------------------
// nzr_receiver
//   Single-pixel WS2812B-style NZR receiver. Decodes the one-wire stream,
//   captures the first 24 bits of a frame as this pixel's GRB colour and
//   forwards every later bit on dataOut so instances can be chained like a
//   physical strip. All timing parameters are in clk cycles.
//
//   Parameters
//     BIT_THRESH    high width (cycles) at or above which a bit decodes as 1
//     MAX_HIGH      high width that flags a stuck-high line (< 256)
//     RESET_CYCLES  low width that ends a frame (< 32768)
//     MIN_HIGH      glitch limit (only with NZR_GLITCH_FILTER_EN)
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous active-low reset
//     bus    nzr_receiver_if.slave (dataIn, dataOut, grb, colorValid,
//            frameErr, rxBusy)
//
//   Build option
//     NZR_GLITCH_FILTER_EN  when defined, high pulses shorter than MIN_HIGH
//                           are ignored by the decoder (still forwarded).
// ---------------------------------------------------------------------------
module nzr_receiver #(
    parameter int unsigned BIT_THRESH   = 60,
    parameter int unsigned MAX_HIGH     = 200,
    parameter int unsigned RESET_CYCLES = 28000
`ifdef NZR_GLITCH_FILTER_EN
    ,
    parameter int unsigned MIN_HIGH     = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    nzr_receiver_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_ERR
    } state_e;

    localparam logic [7:0]  BIT_THRESH_C   = 8'(BIT_THRESH);
    localparam logic [7:0]  MAX_HIGH_C     = 8'(MAX_HIGH);
    localparam logic [14:0] RESET_CYCLES_C = 15'(RESET_CYCLES);
    localparam logic [4:0]  FULL_BITS      = 5'd24;

    state_e      state_q,       state_d;
    logic [1:0]  sync_q,        sync_d;
    logic        din_prev_q,    din_prev_d;
    logic [7:0]  hcnt_q,        hcnt_d;
    logic [14:0] lcnt_q,        lcnt_d;
    logic [4:0]  bit_cnt_q,     bit_cnt_d;
    logic [23:0] shreg_q,       shreg_d;
    logic        pass_q,        pass_d;
    logic        discard_q,     discard_d;
    logic [23:0] grb_q,         grb_d;
    logic        color_valid_q, color_valid_d;
    logic        frame_err_q,   frame_err_d;
    logic        data_out_q,    data_out_d;
    logic        rx_busy_q,     rx_busy_d;

    logic        din;
    logic        rise;
    logic        bit_val;
    logic        glitch;
    logic [7:0]  hcnt_inc;
    logic [14:0] lcnt_inc;
    logic [14:0] lcnt_resume;

    // dataIn is asynchronous: only the second synchronizer stage feeds logic.
    assign din      = sync_q[1];
    assign rise     = din & ~din_prev_q;
    assign hcnt_inc = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;
    assign lcnt_inc = (lcnt_q == 15'h7FFF) ? lcnt_q : lcnt_q + 15'd1;
    assign bit_val  = (hcnt_q >= BIT_THRESH_C);

`ifdef NZR_GLITCH_FILTER_EN
    localparam logic [7:0] MIN_HIGH_C = 8'(MIN_HIGH);
    logic [15:0] lcnt_sum;

    // A rejected spike counts as part of the surrounding low time, so the
    // frame-end timer keeps running through it.
    assign lcnt_sum    = {1'b0, lcnt_q} + {8'd0, hcnt_q} + 16'd1;
    assign glitch      = (hcnt_q < MIN_HIGH_C);
    assign lcnt_resume = lcnt_sum[15] ? 15'h7FFF : lcnt_sum[14:0];
`else
    assign glitch      = 1'b0;
    assign lcnt_resume = 15'd1;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path through
        // the case below can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        sync_d        = {sync_q[0], bus.dataIn};
        din_prev_d    = din;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        pass_d        = pass_q;
        discard_d     = discard_q;
        grb_d         = grb_q;
        color_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        data_out_d    = din & pass_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    hcnt_d  = 8'd1;
                end
            end

            ST_HIGH: begin
                if (din) begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc == MAX_HIGH_C) begin
                        state_d     = ST_ERR;
                        frame_err_d = 1'b1;
                        discard_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_LOW;
                    if (glitch) begin
                        lcnt_d = lcnt_resume;
                    end else begin
                        lcnt_d = 15'd1;
                        // Bits past the 24th are only forwarded, never stored.
                        if (!discard_q && (bit_cnt_q < FULL_BITS)) begin
                            shreg_d   = {shreg_q[22:0], bit_val};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            // Forwarding opens at the 24th decode, before the
                            // rise of bit 25, so no pulse is forwarded clipped.
                            if (bit_cnt_q == FULL_BITS - 5'd1) begin
                                pass_d = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    hcnt_d  = 8'd1;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_CYCLES_C) begin
                        if (!discard_q) begin
                            if (bit_cnt_q == FULL_BITS) begin
                                grb_d         = shreg_q;
                                color_valid_d = 1'b1;
                            end else if (bit_cnt_q != 5'd0) begin
                                frame_err_d = 1'b1;
                            end
                        end
                        state_d   = ST_IDLE;
                        bit_cnt_d = 5'd0;
                        pass_d    = 1'b0;
                        discard_d = 1'b0;
                        hcnt_d    = 8'd0;
                        lcnt_d    = 15'd0;
                    end
                end
            end

            ST_ERR: begin
                if (!din) begin
                    state_d = ST_LOW;
                    lcnt_d  = 15'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sync_q        <= 2'b00;
            din_prev_q    <= 1'b0;
            hcnt_q        <= 8'd0;
            lcnt_q        <= 15'd0;
            bit_cnt_q     <= 5'd0;
            shreg_q       <= 24'd0;
            pass_q        <= 1'b0;
            discard_q     <= 1'b0;
            grb_q         <= 24'd0;
            color_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            data_out_q    <= 1'b0;
            rx_busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every flop samples the pre-edge
            // value of the others regardless of statement order.
            state_q       <= state_d;
            sync_q        <= sync_d;
            din_prev_q    <= din_prev_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            pass_q        <= pass_d;
            discard_q     <= discard_d;
            grb_q         <= grb_d;
            color_valid_q <= color_valid_d;
            frame_err_q   <= frame_err_d;
            data_out_q    <= data_out_d;
            rx_busy_q     <= rx_busy_d;
        end
    end

    assign bus.dataOut    = data_out_q;
    assign bus.grb        = grb_q;
    assign bus.colorValid = color_valid_q;
    assign bus.frameErr   = frame_err_q;
    assign bus.rxBusy     = rx_busy_q;

endmodule

// File: tb/tb_nzr_receiver.sv
// ---------------------------------------------------------------------------
// tb_nzr_receiver
//   Directed bench for nzr_receiver. The frame-end time is shortened to
//   RST cycles so the whole run stays short; every boundary is exercised
//   relative to that value. dataIn is driven on the falling clock edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nzr_receiver;

    localparam int RST = 3000;

`ifdef NZR_GLITCH_FILTER_EN
    localparam bit          SPIKE_DECODES = 1'b0;
    localparam logic [23:0] T6_GRB        = 24'hA5C30F;
`else
    localparam bit          SPIKE_DECODES = 1'b1;
    // A5C30F with a 0 inserted after bit 12: A5C | 0 | 0011_0000_111
    localparam logic [23:0] T6_GRB        = 24'hA5C187;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nzr_receiver_if bus_if ();

    nzr_receiver #(
        .RESET_CYCLES (RST)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor processes).
    int       cyc       = 0;
    logic [2:0] raw_hist = 3'b000;
    int       cv_cnt    = 0;
    int       cv_cyc    = 0;
    int       fe_cnt    = 0;
    int       do_high   = 0;
    int       fwd_mism  = 0;
    int       overlap   = 0;

    // Stimulus-side state (written only by the main process).
    bit fwd_arm       = 1'b0;
    bit fwd_en        = 1'b0;
    int nbits         = 0;
    int last_fall_cyc = 0;
    int cv0, fe0, do0, fm0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        raw_hist <= {raw_hist[1:0], bus_if.dataIn};
    end

    // dataOut must equal the raw line two sample edges back, gated by the
    // bench's own notion of when forwarding is open.
    always @(negedge clk) begin
        if (bus_if.colorValid) begin
            cv_cnt++;
            cv_cyc = cyc;
        end
        if (bus_if.frameErr) fe_cnt++;
        if (bus_if.colorValid && bus_if.frameErr) overlap++;
        if (bus_if.dataOut) do_high++;
        if (bus_if.dataOut !== (raw_hist[2] & fwd_en)) fwd_mism++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse(input int hi, input int lo, input bit counts);
        if (fwd_arm && nbits >= 24) fwd_en = 1'b1;
        bus_if.dataIn = 1'b1;
        repeat (hi) @(negedge clk);
        bus_if.dataIn = 1'b0;
        last_fall_cyc = cyc;
        repeat (lo) @(negedge clk);
        if (counts) nbits++;
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(80, 45, 1'b1);
        else   pulse(40, 85, 1'b1);
    endtask

    task automatic send_range(input logic [23:0] w, input int hi_idx, input int lo_idx);
        for (int i = hi_idx; i >= lo_idx; i--) send_bit(w[i]);
    endtask

    task automatic idle_low(input int n);
        fwd_en        = 1'b0;
        nbits         = 0;
        bus_if.dataIn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus_if.dataIn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_dataOut",    32'(bus_if.dataOut),    32'd0);
        check("rst_grb",        32'(bus_if.grb),        32'h0);
        check("rst_colorValid", 32'(bus_if.colorValid), 32'd0);
        check("rst_frameErr",   32'(bus_if.frameErr),   32'd0);
        check("rst_rxBusy",     32'(bus_if.rxBusy),     32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // T1: single 24-bit frame FF0080, nothing forwarded
        fwd_arm = 1'b1;
        cv0 = cv_cnt; fe0 = fe_cnt; do0 = do_high;
        send_range(24'hFF0080, 23, 12);
        check("t1_busy_mid", 32'(bus_if.rxBusy), 32'd1);
        send_range(24'hFF0080, 11, 0);
        idle_low(RST + 10);
        check("t1_grb",       32'(bus_if.grb), 32'hFF0080);
        check("t1_cv_count",  32'(cv_cnt - cv0), 32'd1);
        check("t1_fe_count",  32'(fe_cnt - fe0), 32'd0);
        check("t1_cv_timing", 32'(cv_cyc - last_fall_cyc), 32'(RST + 2));
        check("t1_dout_quiet", 32'(do_high - do0), 32'd0);
        check("t1_busy_end",  32'(bus_if.rxBusy), 32'd0);

        // T2: 48-bit frame, second word forwarded (17 ones, 7 zeros)
        cv0 = cv_cnt; fe0 = fe_cnt; do0 = do_high; fm0 = fwd_mism;
        send_range(24'h123456, 23, 0);
        send_range(24'hABCDEF, 23, 0);
        idle_low(RST + 10);
        check("t2_grb",       32'(bus_if.grb), 32'h123456);
        check("t2_cv_count",  32'(cv_cnt - cv0), 32'd1);
        check("t2_fe_count",  32'(fe_cnt - fe0), 32'd0);
        check("t2_fwd_high",  32'(do_high - do0), 32'd1640);
        check("t2_fwd_shape", 32'(fwd_mism - fm0), 32'd0);

        // T3: short frame of 10 bits
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_range(24'h3FF000, 23, 14);
        idle_low(RST + 10);
        check("t3_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("t3_cv_count", 32'(cv_cnt - cv0), 32'd0);
        check("t3_grb_kept", 32'(bus_if.grb), 32'h123456);
        check("t3_busy_end", 32'(bus_if.rxBusy), 32'd0);

        // T4: widths 59/60 and a low gap of RST-1 inside the frame
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_range(24'h0F0F0F, 23, 2);
        pulse(59, RST - 1, 1'b1);
        pulse(60, 65, 1'b1);
        check("t4_gap_no_latch", 32'(cv_cnt - cv0), 32'd0);
        idle_low(RST + 10);
        check("t4_grb",      32'(bus_if.grb), 32'h0F0F0D);
        check("t4_cv_count", 32'(cv_cnt - cv0), 32'd1);
        check("t4_fe_count", 32'(fe_cnt - fe0), 32'd0);

        // T5: stuck-high mid-frame poisons the rest of the frame
        fwd_arm = 1'b0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_range(24'hF80000, 23, 19);
        pulse(250, 45, 1'b1);
        send_range(24'h00FFFF, 23, 0);
        idle_low(RST + 10);
        check("t5_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("t5_cv_count", 32'(cv_cnt - cv0), 32'd0);
        check("t5_grb_kept", 32'(bus_if.grb), 32'h0F0F0D);

        // T6: 8-cycle spike after bit 12
        fwd_arm = 1'b1;
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_range(24'hA5C30F, 23, 12);
        pulse(8, 40, SPIKE_DECODES);
        send_range(24'hA5C30F, 11, 0);
        idle_low(RST + 10);
        check("t6_grb",      32'(bus_if.grb), 32'(T6_GRB));
        check("t6_cv_count", 32'(cv_cnt - cv0), 32'd1);
        check("t6_fe_count", 32'(fe_cnt - fe0), 32'd0);

        // T7: reset while forwarding mid-frame
        send_range(24'h5A5A5A, 23, 0);
        send_range(24'h5A5A5A, 23, 18);
        check("t7_busy_pre", 32'(bus_if.rxBusy), 32'd1);
        fwd_en = 1'b0;
        cv0 = cv_cnt; fe0 = fe_cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_rst_grb",     32'(bus_if.grb),     32'h0);
        check("t7_rst_busy",    32'(bus_if.rxBusy),  32'd0);
        check("t7_rst_dataOut", 32'(bus_if.dataOut), 32'd0);
        rst_n = 1'b1;
        idle_low(RST + 10);
        check("t7_cv_count", 32'(cv_cnt - cv0), 32'd0);
        check("t7_fe_count", 32'(fe_cnt - fe0), 32'd0);

        // Whole-run properties
        check("fwd_shape_all", 32'(fwd_mism), 32'd0);
        check("pulse_overlap", 32'(overlap),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
